fb_access_ctrl: RTL and testbench
=================================

// Module: fb_access_ctrl
// PURPOSE
//  Owns both ports of the 1-bit 480x480 binarized frame buffer.
//  Port A: gates camera writes. Sequences LIVE -> ARMED -> CAPTURE -> FROZEN so that
//  exactly one whole camera frame is snapshotted for decoding.
//  Port B: arbitrates reads between the HDMI display path and the QR decoder.
//  Sits between recover/binary, the frame buffer, rotate/scale and the decoder.
// PARAMETERS
//  STORED_WIDTH   480  stored frame width in pixels (row pitch)
//  STORED_HEIGHT  480  stored frame height in rows
//  ADDR_W         18   BRAM address width; must satisfy 2**ADDR_W >= W*H
//  BRAM_LAT       2    read latency of port B, in cycles
// PORTS
//  clk_in          in   1       pixel clock
//  rst_in          in   1       asynchronous reset, active-high
//  capture_req_in  in   1       1-cycle pulse: request a new snapshot
//  release_in      in   1       1-cycle pulse: decoder finished, unfreeze
//  frame_done_in   in   1       1-cycle pulse from camera at end of frame
//  cam_valid_in    in   1       binarized pixel valid
//  cam_hcount_in   in   11      pixel column
//  cam_vcount_in   in   10      pixel row
//  cam_bit_in      in   1       binarized pixel value
//  wea_out         out  1       port A write enable
//  addra_out       out  ADDR_W  port A address
//  dina_out        out  1       port A write data
//  disp_req_in     in   1       display read request (valid_addr from rotate)
//  disp_addr_in    in   ADDR_W  display read address
//  disp_data_out   out  1       display pixel; 0 when not valid
//  disp_valid_out  out  1       disp_data_out valid
//  dec_req_in      in   1       decoder read request; held until granted
//  dec_addr_in     in   ADDR_W  decoder read address; stable while dec_req_in=1
//  dec_gnt_out     out  1       1-cycle grant; request accepted this cycle
//  dec_data_out    out  1       decoder read data
//  dec_valid_out   out  1       dec_data_out valid
//  addrb_out       out  ADDR_W  port B address
//  enb_out         out  1       port B enable
//  doutb_in        in   1       port B read data
//  frame_ready_out out  1       1-cycle pulse on entry to FROZEN
//  state_out       out  2       current FSM state (debug / LEDs)
// BEHAVIOUR
//  Reset (async assert, sync release): state=LIVE. All outputs 0. Read tag pipe cleared.
//  FSM:
//   LIVE    --capture_req--> ARMED
//   ARMED   --frame_done-->  CAPTURE
//   CAPTURE --frame_done-->  FROZEN (frame_ready_out=1 for that cycle)
//   FROZEN  --release-->     LIVE
//  capture_req_in is ignored in ARMED and CAPTURE.
//  release_in is ignored outside FROZEN.
//  In FROZEN, release and capture_req in the same cycle -> ARMED (immediate re-capture).
//  Write path (registered, latency 1):
//   wea_out = cam_valid && hcount<STORED_WIDTH && vcount<STORED_HEIGHT
//             && state in {LIVE, CAPTURE}.
//   addra_out = hcount + STORED_WIDTH*vcount, truncated to ADDR_W.
//   dina_out = cam_bit_in.
//   No writes in ARMED or FROZEN. The snapshot is never partially overwritten.
//  Read arbitration: one port-B issue per cycle; display has fixed priority.
//   disp_req_in=1: issue disp_addr_in, enb_out=1, tag=DISP.
//   Otherwise, if dec_req_in=1 and state==FROZEN: issue dec_addr_in, dec_gnt_out=1, tag=DEC.
//   Otherwise: enb_out=0, tag=NONE.
//   Decoder is never granted outside FROZEN; dec_req_in simply waits.
//   addrb_out/enb_out are combinational from the inputs so that rotate timing holds.
//  Return path: the tag travels through a BRAM_LAT-deep shift register.
//   When the tag exits as DISP: disp_valid_out=1 and disp_data_out=doutb_in; otherwise disp_data_out=0.
//   When the tag exits as DEC: dec_valid_out=1 and dec_data_out=doutb_in.
//   Exactly one return per grant, in order, BRAM_LAT cycles after issue.
//  Leaving FROZEN does not cancel in-flight DEC tags; they still return.
//  Reset mid-operation: in-flight tags are dropped and no valid is produced.
// STRUCTURE
//  fb_ctrl_pkg:
//   - fb_state_t enum: LIVE=0, ARMED=1, CAPTURE=2, FROZEN=3.
//   - rd_tag_t enum: NONE, DISP, DEC.
//   - Default dimension localparams.
//  Sub-module fb_read_arbiter: priority select plus tag shift register and return demux.
//  The FSM and write gating stay in fb_access_ctrl.
// TESTING
//  1) Reset with every input high -> all outputs 0, state_out=0. After release, LIVE writes pass through.
//  2) capture_req, then 2 frame_done pulses, with cam pixel (5,3) -> exactly one CAPTURE frame is written.
//     frame_ready pulses once. wea stays 0 in ARMED and FROZEN. addra of (5,3) = 1445.
//  3) Pixel at h=480 or v=480 -> wea_out=0 in every state.
//  4) FROZEN, disp_req held for 10 cycles, dec_req held -> no dec_gnt until disp_req drops.
//     Then dec_gnt fires and dec_valid follows 2 cycles later with the BRAM data at dec_addr.
//  5) dec_req in LIVE -> never granted. release in FROZEN -> LIVE; an in-flight DEC read still returns.
//  6) rst_in asserted mid-read in FROZEN -> no dec_valid/disp_valid afterwards, state_out=LIVE.

Source files
------------

// File: rtl/fb_ctrl_pkg.sv
// Shared types and default dimensions for the frame-buffer access controller.
package fb_ctrl_pkg;

  localparam int unsigned DEF_STORED_WIDTH  = 480;
  localparam int unsigned DEF_STORED_HEIGHT = 480;
  localparam int unsigned DEF_ADDR_W        = 18;
  localparam int unsigned DEF_BRAM_LAT      = 2;

  typedef enum logic [1:0] {
    LIVE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FROZEN  = 2'd3
  } fb_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    DISP = 2'd1,
    DEC  = 2'd2
  } rd_tag_t;

endpackage

// File: rtl/fb_read_arbiter.sv
// Port-B read arbiter: display has fixed priority, the decoder is served only when allowed.
// A tag per issue rides a BRAM_LAT-deep pipe and steers the returning data.
module fb_read_arbiter
  import fb_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned BRAM_LAT = DEF_BRAM_LAT
) (
  input  logic              clk_pixel,
  input  logic              rst,
  input  logic              dec_allowed,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              dec_req,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic              doutb,
  output logic [ADDR_W-1:0] addrb,
  output logic              enb,
  output logic              dec_gnt,
  output logic              disp_data,
  output logic              disp_valid,
  output logic              dec_data,
  output logic              dec_valid
);

  rd_tag_t issue_tag;
  rd_tag_t tag_pipe_reg [BRAM_LAT];
  rd_tag_t ret_tag;

  // Issue is combinational so the rotate path sees its address the same cycle;
  // it is held off while reset is asserted so nothing leaks out during reset.
  always_comb begin
    issue_tag = NONE;
    addrb     = '0;
    enb       = 1'b0;
    dec_gnt   = 1'b0;
    if (!rst) begin
      if (disp_req) begin
        issue_tag = DISP;
        addrb     = disp_addr;
        enb       = 1'b1;
      end else if (dec_req && dec_allowed) begin
        issue_tag = DEC;
        addrb     = dec_addr;
        enb       = 1'b1;
        dec_gnt   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BRAM_LAT); i++) tag_pipe_reg[i] <= NONE;
    end else begin
      tag_pipe_reg[0] <= issue_tag;
      for (int i = 1; i < int'(BRAM_LAT); i++) tag_pipe_reg[i] <= tag_pipe_reg[i-1];
    end
  end

  assign ret_tag    = tag_pipe_reg[BRAM_LAT-1];
  assign disp_valid = (ret_tag == DISP);
  assign dec_valid  = (ret_tag == DEC);
  assign disp_data  = disp_valid & doutb;
  assign dec_data   = dec_valid & doutb;

endmodule

// File: rtl/fb_access_ctrl.sv
// Owns both ports of the 1-bit binarized frame buffer: snapshot FSM and write gating on
// port A, display/decoder read arbitration on port B.
module fb_access_ctrl
  import fb_ctrl_pkg::*;
#(
  parameter int unsigned STORED_WIDTH  = DEF_STORED_WIDTH,
  parameter int unsigned STORED_HEIGHT = DEF_STORED_HEIGHT,
  parameter int unsigned ADDR_W        = DEF_ADDR_W,
  parameter int unsigned BRAM_LAT      = DEF_BRAM_LAT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              capture_req_in,
  input  logic              release_in,
  input  logic              frame_done_in,
  input  logic              cam_valid_in,
  input  logic [10:0]       cam_hcount_in,
  input  logic [9:0]        cam_vcount_in,
  input  logic              cam_bit_in,
  output logic              wea_out,
  output logic [ADDR_W-1:0] addra_out,
  output logic              dina_out,
  input  logic              disp_req_in,
  input  logic [ADDR_W-1:0] disp_addr_in,
  output logic              disp_data_out,
  output logic              disp_valid_out,
  input  logic              dec_req_in,
  input  logic [ADDR_W-1:0] dec_addr_in,
  output logic              dec_gnt_out,
  output logic              dec_data_out,
  output logic              dec_valid_out,
  output logic [ADDR_W-1:0] addrb_out,
  output logic              enb_out,
  input  logic              doutb_in,
  output logic              frame_ready_out,
  output logic [1:0]        state_out
);

  fb_state_t state_reg, state_next;
  logic              frame_ready;
  logic              wea_reg;
  logic [ADDR_W-1:0] addra_reg;
  logic              dina_reg;
  logic              pix_in_frame;
  logic              write_allowed;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_reg <= LIVE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    frame_ready = 1'b0;
    case (state_reg)
      LIVE:    if (capture_req_in) state_next = ARMED;
      ARMED:   if (frame_done_in) state_next = CAPTURE;
      CAPTURE: begin
        if (frame_done_in) begin
          state_next  = FROZEN;
          frame_ready = 1'b1;
        end
      end
      FROZEN:  if (release_in) state_next = capture_req_in ? ARMED : LIVE;
      default: state_next = LIVE;
    endcase
  end

  // ARMED waits out the partial frame in progress; FROZEN protects the snapshot.
  assign pix_in_frame  = (cam_hcount_in < 11'(STORED_WIDTH)) && (cam_vcount_in < 10'(STORED_HEIGHT));
  assign write_allowed = (state_reg == LIVE) || (state_reg == CAPTURE);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wea_reg   <= 1'b0;
      addra_reg <= '0;
      dina_reg  <= 1'b0;
    end else begin
      wea_reg   <= cam_valid_in && pix_in_frame && write_allowed;
      addra_reg <= ADDR_W'(cam_hcount_in) + ADDR_W'(STORED_WIDTH) * ADDR_W'(cam_vcount_in);
      dina_reg  <= cam_bit_in;
    end
  end

  fb_read_arbiter #(
    .ADDR_W   (ADDR_W),
    .BRAM_LAT (BRAM_LAT)
  ) u_read_arbiter (
    .clk_pixel   (clk_in),
    .rst         (rst_in),
    .dec_allowed (state_reg == FROZEN),
    .disp_req    (disp_req_in),
    .disp_addr   (disp_addr_in),
    .dec_req     (dec_req_in),
    .dec_addr    (dec_addr_in),
    .doutb       (doutb_in),
    .addrb       (addrb_out),
    .enb         (enb_out),
    .dec_gnt     (dec_gnt_out),
    .disp_data   (disp_data_out),
    .disp_valid  (disp_valid_out),
    .dec_data    (dec_data_out),
    .dec_valid   (dec_valid_out)
  );

  assign wea_out         = wea_reg;
  assign addra_out       = addra_reg;
  assign dina_out        = dina_reg;
  assign frame_ready_out = frame_ready;
  assign state_out       = state_reg;

endmodule

// File: tb/tb_fb_access_ctrl.sv
// Directed bench for fb_access_ctrl with a small two-stage BRAM model on port B.
module tb_fb_access_ctrl;

  localparam int ADDR_W = 18;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              capture_req_in, release_in, frame_done_in;
  logic              cam_valid_in, cam_bit_in;
  logic [10:0]       cam_hcount_in;
  logic [9:0]        cam_vcount_in;
  logic              wea_out, dina_out;
  logic [ADDR_W-1:0] addra_out;
  logic              disp_req_in, disp_data_out, disp_valid_out;
  logic [ADDR_W-1:0] disp_addr_in;
  logic              dec_req_in, dec_gnt_out, dec_data_out, dec_valid_out;
  logic [ADDR_W-1:0] dec_addr_in;
  logic [ADDR_W-1:0] addrb_out;
  logic              enb_out, doutb_in;
  logic              frame_ready_out;
  logic [1:0]        state_out;

  int checks   = 0;
  int failures = 0;

  fb_access_ctrl #(
    .STORED_WIDTH  (480),
    .STORED_HEIGHT (480),
    .ADDR_W        (ADDR_W),
    .BRAM_LAT      (2)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .capture_req_in  (capture_req_in),
    .release_in      (release_in),
    .frame_done_in   (frame_done_in),
    .cam_valid_in    (cam_valid_in),
    .cam_hcount_in   (cam_hcount_in),
    .cam_vcount_in   (cam_vcount_in),
    .cam_bit_in      (cam_bit_in),
    .wea_out         (wea_out),
    .addra_out       (addra_out),
    .dina_out        (dina_out),
    .disp_req_in     (disp_req_in),
    .disp_addr_in    (disp_addr_in),
    .disp_data_out   (disp_data_out),
    .disp_valid_out  (disp_valid_out),
    .dec_req_in      (dec_req_in),
    .dec_addr_in     (dec_addr_in),
    .dec_gnt_out     (dec_gnt_out),
    .dec_data_out    (dec_data_out),
    .dec_valid_out   (dec_valid_out),
    .addrb_out       (addrb_out),
    .enb_out         (enb_out),
    .doutb_in        (doutb_in),
    .frame_ready_out (frame_ready_out),
    .state_out       (state_out)
  );

  always #5 clk_in = ~clk_in;

  // BRAM model: content is a fixed function of address, two-cycle read latency.
  logic bram_p1 = 1'b0;
  logic bram_p2 = 1'b0;
  logic dout_force;

  function automatic logic mem_bit(input logic [ADDR_W-1:0] a);
    return a[0] ^ a[2];
  endfunction

  always @(posedge clk_in) begin
    if (enb_out) bram_p1 <= mem_bit(addrb_out);
    bram_p2 <= bram_p1;
  end

  assign doutb_in = dout_force | bram_p2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_pix(input logic v, input int h, input int vc, input logic b);
    cam_valid_in  = v;
    cam_hcount_in = 11'(h);
    cam_vcount_in = 10'(vc);
    cam_bit_in    = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    // 1) reset with every input high
    rst_in = 1'b1; capture_req_in = 1'b1; release_in = 1'b1; frame_done_in = 1'b1;
    cam_valid_in = 1'b1; cam_hcount_in = '1; cam_vcount_in = '1; cam_bit_in = 1'b1;
    disp_req_in = 1'b1; disp_addr_in = '1; dec_req_in = 1'b1; dec_addr_in = '1;
    dout_force = 1'b1;
    tick(); tick(); tick();
    #2;
    chk("rst_state", 32'(state_out), 0);
    chk("rst_wea", 32'(wea_out), 0);
    chk("rst_addra", 32'(addra_out), 0);
    chk("rst_dina", 32'(dina_out), 0);
    chk("rst_enb", 32'(enb_out), 0);
    chk("rst_addrb", 32'(addrb_out), 0);
    chk("rst_dec_gnt", 32'(dec_gnt_out), 0);
    chk("rst_disp_valid", 32'(disp_valid_out), 0);
    chk("rst_disp_data", 32'(disp_data_out), 0);
    chk("rst_dec_valid", 32'(dec_valid_out), 0);
    chk("rst_dec_data", 32'(dec_data_out), 0);
    chk("rst_frame_ready", 32'(frame_ready_out), 0);

    tick();
    rst_in = 1'b0; capture_req_in = 1'b0; release_in = 1'b0; frame_done_in = 1'b0;
    disp_req_in = 1'b0; disp_addr_in = '0; dec_req_in = 1'b0; dec_addr_in = '0;
    dout_force = 1'b0;
    set_pix(1'b1, 5, 3, 1'b1);
    tick();
    chk("live_state", 32'(state_out), 0);
    chk("live_wea", 32'(wea_out), 1);
    chk("live_addra", 32'(addra_out), 1445);
    chk("live_dina", 32'(dina_out), 1);

    // 3) out-of-frame pixels and the last in-frame pixel
    set_pix(1'b1, 480, 3, 1'b1); tick();
    chk("live_h480_wea", 32'(wea_out), 0);
    set_pix(1'b1, 5, 480, 1'b1); tick();
    chk("live_v480_wea", 32'(wea_out), 0);
    set_pix(1'b1, 479, 479, 1'b0); tick();
    chk("live_last_wea", 32'(wea_out), 1);
    chk("live_last_addra", 32'(addra_out), 230399);
    chk("live_last_dina", 32'(dina_out), 0);
    set_pix(1'b0, 5, 3, 1'b1); tick();
    chk("live_invalid_wea", 32'(wea_out), 0);

    // 2) snapshot sequence
    release_in = 1'b1; tick(); release_in = 1'b0;
    chk("live_release_ignored", 32'(state_out), 0);
    capture_req_in = 1'b1; tick(); capture_req_in = 1'b0;
    chk("armed_state", 32'(state_out), 1);
    set_pix(1'b1, 5, 3, 1'b1); tick();
    chk("armed_wea", 32'(wea_out), 0);
    capture_req_in = 1'b1; release_in = 1'b1; tick();
    capture_req_in = 1'b0; release_in = 1'b0;
    chk("armed_ignores_req", 32'(state_out), 1);
    frame_done_in = 1'b1; #2;
    chk("armed_no_ready", 32'(frame_ready_out), 0);
    tick(); frame_done_in = 1'b0;
    chk("armed_fd_wea", 32'(wea_out), 0);
    chk("capture_state", 32'(state_out), 2);
    tick();
    chk("capture_wea", 32'(wea_out), 1);
    chk("capture_addra", 32'(addra_out), 1445);
    set_pix(1'b1, 480, 0, 1'b1); tick();
    chk("capture_h480_wea", 32'(wea_out), 0);
    set_pix(1'b1, 5, 3, 1'b1);
    frame_done_in = 1'b1; #2;
    chk("capture_frame_ready", 32'(frame_ready_out), 1);
    tick(); frame_done_in = 1'b0;
    chk("frozen_state", 32'(state_out), 3);
    chk("frozen_ready_once", 32'(frame_ready_out), 0);
    tick();
    chk("frozen_wea", 32'(wea_out), 0);
    capture_req_in = 1'b1; tick(); capture_req_in = 1'b0;
    chk("frozen_ignores_req", 32'(state_out), 3);
    set_pix(1'b0, 0, 0, 1'b0);

    // 4) display priority over decoder in FROZEN
    disp_req_in = 1'b1; disp_addr_in = 18'd1;
    dec_req_in  = 1'b1; dec_addr_in  = 18'd4;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk("prio_dec_gnt", 32'(dec_gnt_out), 0);
      chk("prio_addrb", 32'(addrb_out), 1);
      if (i >= 2) chk("prio_disp_data", 32'({disp_valid_out, disp_data_out}), 3);
      tick();
    end
    disp_req_in = 1'b0; #2;
    chk("dec_gnt", 32'(dec_gnt_out), 1);
    chk("dec_addrb", 32'(addrb_out), 4);
    chk("dec_enb", 32'(enb_out), 1);
    tick(); dec_req_in = 1'b0; #2;
    chk("dec_gnt_once", 32'(dec_gnt_out), 0);
    chk("dec_valid_lat1", 32'(dec_valid_out), 0);
    chk("disp_tail_valid", 32'(disp_valid_out), 1);
    tick(); #2;
    chk("dec_valid_lat2", 32'(dec_valid_out), 1);
    chk("dec_data_lat2", 32'(dec_data_out), 1);
    chk("disp_after_tail", 32'(disp_valid_out), 0);
    tick(); #2;
    chk("dec_valid_single", 32'(dec_valid_out), 0);

    // 5) release with an in-flight decoder read, then decoder request in LIVE
    dec_req_in = 1'b1; dec_addr_in = 18'd5; release_in = 1'b1; #2;
    chk("rel_dec_gnt", 32'(dec_gnt_out), 1);
    tick(); dec_req_in = 1'b0; release_in = 1'b0;
    chk("rel_state_live", 32'(state_out), 0);
    tick(); #2;
    chk("rel_dec_valid", 32'(dec_valid_out), 1);
    chk("rel_dec_data", 32'(dec_data_out), 0);
    tick();
    dec_req_in = 1'b1; dec_addr_in = 18'd4;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("live_dec_gnt", 32'(dec_gnt_out), 0);
      chk("live_dec_enb", 32'(enb_out), 0);
      tick();
    end
    #2;
    chk("live_dec_no_valid", 32'(dec_valid_out), 0);
    dec_req_in = 1'b0;

    // re-capture: release together with capture_req in FROZEN
    tick();
    capture_req_in = 1'b1; tick(); capture_req_in = 1'b0;
    frame_done_in = 1'b1; tick(); tick(); frame_done_in = 1'b0;
    chk("frozen_again", 32'(state_out), 3);
    release_in = 1'b1; capture_req_in = 1'b1; tick();
    release_in = 1'b0; capture_req_in = 1'b0;
    chk("recapture_armed", 32'(state_out), 1);
    frame_done_in = 1'b1; tick(); tick(); frame_done_in = 1'b0;
    chk("frozen_third", 32'(state_out), 3);

    // 6) reset in the middle of reads
    dec_req_in = 1'b1; dec_addr_in = 18'd4; #2;
    chk("mid_dec_gnt", 32'(dec_gnt_out), 1);
    tick(); dec_req_in = 1'b0; disp_req_in = 1'b1; disp_addr_in = 18'd1;
    #2; rst_in = 1'b1; #1;
    chk("mid_rst_state", 32'(state_out), 0);
    chk("mid_rst_enb", 32'(enb_out), 0);
    tick(); rst_in = 1'b0; disp_req_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("post_rst_valids", 32'({dec_valid_out, disp_valid_out}), 0);
      tick();
    end
    chk("post_rst_state", 32'(state_out), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
